pipeline_hazard_ctrl: RTL and testbench

- Hazard and sequencing controller for the 5-stage MIPS pipeline.
- Drives the write-enable, bubble and flush controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Detects load-use hazards against the ID/EX stage contents, and flushes on taken branches or jumps resolved in ID.
- Freezes the whole pipeline while data memory is busy, with a timeout watchdog and saturating stall/flush statistics counters.

---
 rtl/hazard_pkg.sv | 12 +
 rtl/sat_counter.sv | 26 ++
 rtl/pipeline_hazard_ctrl.sv | 128 ++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encodings and register constants.
package hazard_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the stall and flush statistics.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_r;

  // Count up on inc and hold at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {W{1'b0}};
    end else if (inc && (count_r != {W{1'b1}})) begin
      count_r <= count_r + {{(W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for a 5-stage MIPS pipeline: load-use stalls,
// branch/jump flushes, memory-busy freeze with timeout watchdog and statistics.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int MAX_WAIT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             id_branch_taken,
  input  logic             id_jump,
  input  logic             mem_busy,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             ex_mem_write,
  output logic             mem_wb_bubble,
  output logic             err,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  state_e            state_r;
  state_e            state_nxt_s;
  logic [WAIT_W-1:0] wait_cnt_r;
  logic [WAIT_W-1:0] wait_cnt_nxt_s;
  logic              err_r;
  logic              lu_s;
  logic              stall_inc_s;

  // Load-use: the ID/EX load writes a register the ID instruction reads.
  always_comb begin
    lu_s = ex_mem_read && (ex_rt != REG_ZERO) &&
           ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  end

  // Control decode and next-state; the release cycle of MEM_WAIT decodes exactly like RUN.
  always_comb begin
    pc_write       = 1'b1;
    if_id_write    = 1'b1;
    if_id_flush    = 1'b0;
    id_ex_bubble   = 1'b0;
    ex_mem_write   = 1'b1;
    mem_wb_bubble  = 1'b0;
    state_nxt_s    = state_r;
    wait_cnt_nxt_s = wait_cnt_r;
    case (state_r)
      ST_RUN, ST_MEM_WAIT: begin
        if (mem_busy) begin
          pc_write       = 1'b0;
          if_id_write    = 1'b0;
          ex_mem_write   = 1'b0;
          mem_wb_bubble  = 1'b1;
          wait_cnt_nxt_s = wait_cnt_r + {{(WAIT_W-1){1'b0}}, 1'b1};
          if ((state_r == ST_MEM_WAIT) && (wait_cnt_r == WAIT_LAST)) begin
            state_nxt_s = ST_ERROR;
          end else begin
            state_nxt_s = ST_MEM_WAIT;
          end
        end else begin
          state_nxt_s    = ST_RUN;
          wait_cnt_nxt_s = {WAIT_W{1'b0}};
          if (lu_s) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
          end else if (id_branch_taken || id_jump) begin
            if_id_flush = 1'b1;
          end else begin
            if_id_flush = 1'b0;
          end
        end
      end
      default: begin
        // ERROR (and any illegal encoding) freezes the pipeline until reset.
        pc_write       = 1'b0;
        if_id_write    = 1'b0;
        ex_mem_write   = 1'b0;
        mem_wb_bubble  = 1'b1;
        state_nxt_s    = ST_ERROR;
        wait_cnt_nxt_s = {WAIT_W{1'b0}};
      end
    endcase
  end

  // State, wait counter and sticky timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_RUN;
      wait_cnt_r <= {WAIT_W{1'b0}};
      err_r      <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      wait_cnt_r <= wait_cnt_nxt_s;
      err_r      <= err_r || (state_nxt_s == ST_ERROR);
    end
  end

  assign stall_inc_s = !pc_write && (state_r != ST_ERROR);
  assign err         = err_r;
  assign state       = state_r;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_inc_s),
    .count (stall_count)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (if_id_flush),
    .count (flush_count)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed scoreboard bench for pipeline_hazard_ctrl (CNT_W=4, MAX_WAIT=64).
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W    = 4;
  localparam int MAX_WAIT = 64;

  // {pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_write, mem_wb_bubble}
  localparam logic [5:0] C_NORM  = 6'b110010;
  localparam logic [5:0] C_LU    = 6'b000110;
  localparam logic [5:0] C_FLUSH = 6'b111010;
  localparam logic [5:0] C_MEM   = 6'b000001;

  typedef struct {
    logic [5:0]       ctrl;
    logic [1:0]       st;
    logic [CNT_W-1:0] stall;
    logic [CNT_W-1:0] flush;
    logic             err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] id_rs = 5'd0, id_rt = 5'd0, ex_rt = 5'd0;
  logic id_uses_rt = 1'b0, ex_mem_read = 1'b0, id_branch_taken = 1'b0;
  logic id_jump = 1'b0, mem_busy = 1'b0;
  logic pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_write, mem_wb_bubble, err;
  logic [1:0] state;
  logic [CNT_W-1:0] stall_count, flush_count;

  int tests = 0;
  int fails = 0;
  exp_t sb[$];
  logic [CNT_W-1:0] m_stall = '0;
  logic [CNT_W-1:0] m_flush = '0;

  pipeline_hazard_ctrl #(.CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .id_branch_taken(id_branch_taken),
    .id_jump(id_jump), .mem_busy(mem_busy), .pc_write(pc_write), .if_id_write(if_id_write),
    .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble), .ex_mem_write(ex_mem_write),
    .mem_wb_bubble(mem_wb_bubble), .err(err), .state(state),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic rd, input logic [4:0] xrt, input logic [4:0] rs,
                       input logic [4:0] rt, input logic urt, input logic br,
                       input logic jp, input logic busy);
    ex_mem_read = rd; ex_rt = xrt; id_rs = rs; id_rt = rt;
    id_uses_rt = urt; id_branch_taken = br; id_jump = jp; mem_busy = busy;
  endtask

  task automatic compare_pop(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      tests++; fails++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, ".ctrl"}, 32'({pc_write, if_id_write, if_id_flush, id_ex_bubble,
                                ex_mem_write, mem_wb_bubble}), 32'(e.ctrl));
      chk({tag, ".state"}, 32'(state), 32'(e.st));
      chk({tag, ".stall"}, 32'(stall_count), 32'(e.stall));
      chk({tag, ".flush"}, 32'(flush_count), 32'(e.flush));
      chk({tag, ".err"}, 32'(err), 32'(e.err));
    end
  endtask

  // One pipeline cycle: drive after the edge, push the expectation, check at the falling edge.
  task automatic step(input string tag, input logic rd, input logic [4:0] xrt,
                      input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                      input logic br, input logic jp, input logic busy,
                      input logic [5:0] ctrl, input logic [1:0] st);
    exp_t e;
    @(posedge clk); #1;
    drive(rd, xrt, rs, rt, urt, br, jp, busy);
    e.ctrl = ctrl; e.st = st; e.stall = m_stall; e.flush = m_flush; e.err = (st == 2'd2);
    sb.push_back(e);
    @(negedge clk);
    compare_pop(tag);
    if (!ctrl[5] && (st != 2'd2) && (m_stall != {CNT_W{1'b1}})) m_stall = m_stall + 1'b1;
    if (ctrl[3] && (m_flush != {CNT_W{1'b1}})) m_flush = m_flush + 1'b1;
  endtask

  task automatic idle(input string tag, input logic [1:0] st);
    step(tag, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_NORM, st);
  endtask

  task automatic do_reset(input string tag);
    exp_t e;
    @(negedge clk);
    rst_n = 1'b0;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    m_stall = '0; m_flush = '0;
    e.ctrl = C_NORM; e.st = 2'd0; e.stall = '0; e.flush = '0; e.err = 1'b0;
    sb.push_back(e);
    compare_pop(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset("reset");
    idle("post_reset", 2'd0);

    step("lu_rs", 1'b1, 5'd8, 5'd8, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, C_LU, 2'd0);
    step("lu_r0", 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, C_NORM, 2'd0);
    step("lu_nort", 1'b1, 5'd9, 5'd1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, C_NORM, 2'd0);

    step("lu_br", 1'b1, 5'd9, 5'd2, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, C_LU, 2'd0);
    step("br_after", 1'b0, 5'd9, 5'd2, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, C_FLUSH, 2'd0);
    step("jump", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, C_FLUSH, 2'd0);
    idle("after_flush", 2'd0);

    step("busy1", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, C_MEM, 2'd0);
    step("busy2", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, C_MEM, 2'd1);
    step("busy3", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, C_MEM, 2'd1);
    idle("release", 2'd1);
    idle("run_again", 2'd0);

    step("busy_br", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, C_MEM, 2'd0);
    step("rel_br", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, C_FLUSH, 2'd1);
    step("busy_lu", 1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, C_MEM, 2'd0);
    step("rel_lu", 1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_LU, 2'd1);
    idle("after_lu", 2'd0);

    step("wait_a", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, C_MEM, 2'd0);
    step("wait_b", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, C_MEM, 2'd1);
    do_reset("reset_mid_wait");
    idle("post_reset2", 2'd0);

    for (int i = 0; i < (1 << CNT_W) + 5; i++) begin
      step("sat_lu", 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_LU, 2'd0);
    end
    idle("sat_hold", 2'd0);
    chk("stall_sat", 32'(stall_count), 32'(15));

    do_reset("reset3");
    for (int i = 0; i < MAX_WAIT; i++) begin
      step("timeout", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, C_MEM,
           (i == 0) ? 2'd0 : 2'd1);
    end
    step("error", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, C_MEM, 2'd2);
    step("error_rel", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, C_MEM, 2'd2);
    step("error_hold", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_MEM, 2'd2);
    do_reset("reset_err");
    idle("final", 2'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
